// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared by every backend pipeline stage.
//   - reset-active level and true/false constants
//   - default payload widths of the ID, EXE and WB stage buses
//   - field offsets inside those buses, so producers and consumers slice
//     them identically
package pipe_pkg;

  localparam logic RESET_ACTIVE = 1'b1;
  localparam logic TRUE         = 1'b1;
  localparam logic FALSE        = 1'b0;

  // Default payload widths per stage bus
  localparam int ID_BUS_W  = 134;
  localparam int EXE_BUS_W = 166;
  localparam int WB_BUS_W  = 166;

  // ID bus: {ctrl[37:0], imm[31:0], inst[31:0], pc[31:0]}
  localparam int ID_PC_LSB    = 0;
  localparam int ID_INST_LSB  = 32;
  localparam int ID_IMM_LSB   = 64;
  localparam int ID_CTRL_LSB  = 96;

  // EXE bus: {ctrl[37:0], rs2[31:0], alu[63:0], pc[31:0]}
  localparam int EXE_PC_LSB   = 0;
  localparam int EXE_ALU_LSB  = 32;
  localparam int EXE_RS2_LSB  = 96;
  localparam int EXE_CTRL_LSB = 128;

  // WB bus: {ctrl[37:0], rd[4:0], wdata[63:0], inst[26:0], pc[31:0]}
  localparam int WB_PC_LSB    = 0;
  localparam int WB_INST_LSB  = 32;
  localparam int WB_WDATA_LSB = 59;
  localparam int WB_RD_LSB    = 123;
  localparam int WB_CTRL_LSB  = 128;

endpackage

// File: rtl/pipe_stage_if.sv
// pipe_stage_if: one valid/ready channel carrying a DATA_W-bit payload.
//   valid  : producer holds a payload on data
//   ready  : consumer can take it this cycle
//   data   : payload
// Handshake: a transfer happens on every rising edge where valid & ready are
// both 1. Once valid is raised, the producer keeps valid and data stable until
// that transfer (except on flush/reset, which discard the item). Ready may
// change freely and must not depend on valid in a way that creates a loop.
// Modports: master = producer side, slave = consumer side.
interface pipe_stage_if #(
  parameter int DATA_W = 166
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stall_counter.sv
// pipe_stall_counter: wrapping CNT_W-bit event counter.
//   clk    : clock
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count one event this cycle
//   cnt_o  : current count, wraps modulo 2^CNT_W, no saturation
module pipe_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register between two backend stages.
//   clk        : clock
//   reset      : synchronous active-high reset
//   flush      : drop all held entries and any same-cycle input
//   in_if      : upstream channel (slave side)
//   out_if     : downstream channel (master side), head entry
//   occupancy  : number of valid entries (0..1 or 0..2)
//   stall_cnt  : cycles with out valid, not ready, no flush (wrapping)
// SKID=0: one entry, in_ready depends combinationally on out_ready.
// SKID=1: two entries (main + skid), in_ready is registered, so no
//         combinational path from out_ready back to in_ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 166,
  parameter int SKID   = 0,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_if.slave      in_if,
  pipe_stage_if.master     out_if,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              skid_v_q;
  logic              in_ready;
  logic              in_fire, out_fire;

  assign in_fire      = in_if.valid & in_ready;
  assign out_fire     = main_v_q & out_if.ready;
  assign in_if.ready  = in_ready;
  assign out_if.valid = main_v_q;
  assign out_if.data  = main_q;
  assign occupancy    = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      main_v_q <= FALSE;
      main_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
    end
  end

  if (SKID == 0) begin : g_single
    assign skid_v_q = FALSE;
    // Can take a new item when empty or when the held one leaves this cycle.
    assign in_ready = ~reset & (~main_v_q | out_if.ready);

    always_comb begin
      main_v_d = main_v_q;
      main_d   = main_q;
      if (flush) begin
        main_v_d = FALSE;
      end else if (in_fire) begin
        main_v_d = TRUE;
        main_d   = in_if.data;
      end else if (out_fire) begin
        main_v_d = FALSE;
      end
    end
  end else begin : g_skid
    logic              skid_v_r, skid_v_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;

    assign skid_v_q = skid_v_r;
    // Registered ready; reset masks it so nothing is accepted during reset.
    assign in_ready = ~reset & in_ready_q;

    always_comb begin
      main_v_d = main_v_q;
      main_d   = main_q;
      skid_v_d = skid_v_r;
      skid_d   = skid_q;
      if (flush) begin
        main_v_d = FALSE;
        skid_v_d = FALSE;
      end else begin
        case ({in_fire, out_fire})
          2'b11: begin
            // Head leaves and a new item arrives: head refills, occupancy same.
            if (skid_v_r) begin
              main_d = skid_q;
              skid_d = in_if.data;
            end else begin
              main_d = in_if.data;
            end
          end
          2'b10: begin
            if (!main_v_q) begin
              main_v_d = TRUE;
              main_d   = in_if.data;
            end else begin
              skid_v_d = TRUE;
              skid_d   = in_if.data;
            end
          end
          2'b01: begin
            if (skid_v_r) begin
              main_d   = skid_q;
              skid_v_d = FALSE;
            end else begin
              main_v_d = FALSE;
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset == RESET_ACTIVE) begin
        skid_v_r   <= FALSE;
        skid_q     <= '0;
        in_ready_q <= TRUE;
      end else begin
        skid_v_r   <= skid_v_d;
        skid_q     <= skid_d;
        in_ready_q <= ~skid_v_d;
      end
    end
  end

  pipe_stall_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (reset == RESET_ACTIVE),
    .en_i  (main_v_q & ~out_if.ready & ~flush),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed bench for pipe_stage.
//   u_a : SKID=0, CNT_W=8
//   u_b : SKID=1, CNT_W=8
//   u_c : SKID=0, CNT_W=4 (counter wrap)
module tb_pipe_stage;

  logic clk;
  logic rst;
  logic a_flush, b_flush, c_flush;
  logic [1:0] a_occ, b_occ, c_occ;
  logic [7:0] a_stall, b_stall;
  logic [3:0] c_stall;
  int checks;
  int failures;

  pipe_stage_if #(.DATA_W(8)) a_in ();
  pipe_stage_if #(.DATA_W(8)) a_out ();
  pipe_stage_if #(.DATA_W(8)) b_in ();
  pipe_stage_if #(.DATA_W(8)) b_out ();
  pipe_stage_if #(.DATA_W(8)) c_in ();
  pipe_stage_if #(.DATA_W(8)) c_out ();

  pipe_stage #(.DATA_W(8), .SKID(0), .CNT_W(8)) u_a (
    .clk(clk), .reset(rst), .flush(a_flush), .in_if(a_in), .out_if(a_out),
    .occupancy(a_occ), .stall_cnt(a_stall));
  pipe_stage #(.DATA_W(8), .SKID(1), .CNT_W(8)) u_b (
    .clk(clk), .reset(rst), .flush(b_flush), .in_if(b_in), .out_if(b_out),
    .occupancy(b_occ), .stall_cnt(b_stall));
  pipe_stage #(.DATA_W(8), .SKID(0), .CNT_W(4)) u_c (
    .clk(clk), .reset(rst), .flush(c_flush), .in_if(c_in), .out_if(c_out),
    .occupancy(c_occ), .stall_cnt(c_stall));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_flush = 0; b_flush = 0; c_flush = 0;
    a_in.valid = 0; a_in.data = '0; a_out.ready = 0;
    b_in.valid = 0; b_in.data = '0; b_out.ready = 0;
    c_in.valid = 0; c_in.data = '0; c_out.ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    checks++;
    if (a_in.ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready_during got=%b exp=0", a_in.ready); end
    step();
    step();
    checks++;
    if (b_in.ready !== 1'b0) begin failures++; $display("FAIL rst_b_ready_during got=%b exp=0", b_in.ready); end
    checks++;
    if (a_out.valid !== 1'b0 || a_out.data !== 8'h00 || a_occ !== 2'd0 || a_stall !== 8'd0) begin
      failures++; $display("FAIL rst_a_state valid=%b data=%h occ=%0d stall=%0d exp=0/00/0/0", a_out.valid, a_out.data, a_occ, a_stall);
    end
    checks++;
    if (b_out.valid !== 1'b0 || b_out.data !== 8'h00 || b_occ !== 2'd0 || b_stall !== 8'd0) begin
      failures++; $display("FAIL rst_b_state valid=%b data=%h occ=%0d stall=%0d exp=0/00/0/0", b_out.valid, b_out.data, b_occ, b_stall);
    end
    rst = 0;
    #1;
    checks++;
    if (a_in.ready !== 1'b1 || b_in.ready !== 1'b1) begin
      failures++; $display("FAIL rst_ready_after a=%b b=%b exp=1/1", a_in.ready, b_in.ready);
    end
  endtask

  // Same stream into both modes; each should deliver one item per cycle.
  task automatic test_streaming();
    do_reset();
    a_in.valid = 1; b_in.valid = 1;
    a_out.ready = 1; b_out.ready = 1;
    a_in.data = 8'h01; b_in.data = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (a_out.valid !== 1'b1 || a_out.data !== 8'(i)) begin
        failures++; $display("FAIL stream_a_%0d valid=%b data=%h exp=1/%h", i, a_out.valid, a_out.data, 8'(i));
      end
      checks++;
      if (b_out.valid !== 1'b1 || b_out.data !== 8'(i) || b_in.ready !== 1'b1) begin
        failures++; $display("FAIL stream_b_%0d valid=%b data=%h ready=%b exp=1/%h/1", i, b_out.valid, b_out.data, b_in.ready, 8'(i));
      end
      if (i < 8) begin
        a_in.data = 8'(i + 1); b_in.data = 8'(i + 1);
      end else begin
        a_in.valid = 0; b_in.valid = 0;
      end
    end
    step();
    checks++;
    if (a_out.valid !== 1'b0 || b_out.valid !== 1'b0 || a_stall !== 8'd0 || b_stall !== 8'd0) begin
      failures++; $display("FAIL stream_drain a_v=%b b_v=%b a_st=%0d b_st=%0d exp=0/0/0/0", a_out.valid, b_out.valid, a_stall, b_stall);
    end
  endtask

  task automatic test_skid_backpressure();
    do_reset();
    b_in.valid = 1; b_in.data = 8'h0A; b_out.ready = 1;
    step();
    b_out.ready = 0; b_in.data = 8'h0B;
    #1;
    checks++;
    if (b_out.data !== 8'h0A || b_in.ready !== 1'b1) begin
      failures++; $display("FAIL skid_a_head data=%h ready=%b exp=0a/1", b_out.data, b_in.ready);
    end
    step();
    checks++;
    if (b_occ !== 2'd2 || b_in.ready !== 1'b0 || b_out.data !== 8'h0A) begin
      failures++; $display("FAIL skid_full occ=%0d ready=%b data=%h exp=2/0/0a", b_occ, b_in.ready, b_out.data);
    end
    b_in.data = 8'h0C;
    step();
    checks++;
    if (b_occ !== 2'd2 || b_in.ready !== 1'b0 || b_out.data !== 8'h0A) begin
      failures++; $display("FAIL skid_hold occ=%0d ready=%b data=%h exp=2/0/0a", b_occ, b_in.ready, b_out.data);
    end
    b_out.ready = 1;
    step();
    checks++;
    if (b_out.data !== 8'h0B || b_occ !== 2'd1 || b_in.ready !== 1'b1) begin
      failures++; $display("FAIL skid_out_b data=%h occ=%0d ready=%b exp=0b/1/1", b_out.data, b_occ, b_in.ready);
    end
    step();
    b_in.valid = 0;
    checks++;
    if (b_out.data !== 8'h0C || b_occ !== 2'd1) begin
      failures++; $display("FAIL skid_out_c data=%h occ=%0d exp=0c/1", b_out.data, b_occ);
    end
    step();
    checks++;
    if (b_out.valid !== 1'b0 || b_stall !== 8'd2) begin
      failures++; $display("FAIL skid_drain valid=%b stall=%0d exp=0/2", b_out.valid, b_stall);
    end
  endtask

  task automatic test_single_backpressure();
    do_reset();
    a_in.valid = 1; a_in.data = 8'h55; a_out.ready = 1;
    step();
    a_out.ready = 0; a_in.data = 8'h66;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++;
      if (a_in.ready !== 1'b0) begin failures++; $display("FAIL bp0_ready_%0d got=%b exp=0", k, a_in.ready); end
      step();
      checks++;
      if (a_out.data !== 8'h55 || a_stall !== 8'(k)) begin
        failures++; $display("FAIL bp0_hold_%0d data=%h stall=%0d exp=55/%0d", k, a_out.data, a_stall, k);
      end
    end
    a_in.valid = 0; a_out.ready = 1;
    step();
    checks++;
    if (a_out.valid !== 1'b0 || a_stall !== 8'd5) begin
      failures++; $display("FAIL bp0_release valid=%b stall=%0d exp=0/5", a_out.valid, a_stall);
    end
  endtask

  task automatic test_flush();
    do_reset();
    b_in.valid = 1; b_in.data = 8'h11; b_out.ready = 0;
    step();
    b_in.data = 8'h22;
    step();
    checks++;
    if (b_occ !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", b_occ); end
    b_in.data = 8'h77; b_flush = 1;
    step();
    b_flush = 0; b_in.valid = 0;
    #1;
    checks++;
    if (b_occ !== 2'd0 || b_out.valid !== 1'b0 || b_in.ready !== 1'b1 || b_stall !== 8'd1) begin
      failures++; $display("FAIL flush_b occ=%0d valid=%b ready=%b stall=%0d exp=0/0/1/1", b_occ, b_out.valid, b_in.ready, b_stall);
    end
    b_out.ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (b_out.valid !== 1'b0) begin failures++; $display("FAIL flush_b_quiet_%0d valid=%b data=%h exp=0", k, b_out.valid, b_out.data); end
    end
    // Single-entry: an accepted-looking input in the flush cycle is dropped.
    a_in.valid = 1; a_in.data = 8'h77; a_out.ready = 1; a_flush = 1;
    step();
    a_flush = 0; a_in.valid = 0;
    checks++;
    if (a_out.valid !== 1'b0 || a_occ !== 2'd0) begin
      failures++; $display("FAIL flush_a_drop valid=%b occ=%0d exp=0/0", a_out.valid, a_occ);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    a_in.valid = 1; a_in.data = 8'h33; a_out.ready = 1;
    step();
    a_in.valid = 0; a_out.ready = 0;
    for (int k = 0; k < 12; k++) step();
    checks++;
    if (a_out.data !== 8'h33 || a_stall !== 8'd12) begin
      failures++; $display("FAIL mid_pre data=%h stall=%0d exp=33/12", a_out.data, a_stall);
    end
    rst = 1;
    #1;
    checks++;
    if (a_in.ready !== 1'b0) begin failures++; $display("FAIL mid_ready_during got=%b exp=0", a_in.ready); end
    step();
    checks++;
    if (a_out.valid !== 1'b0 || a_out.data !== 8'h00 || a_occ !== 2'd0 || a_stall !== 8'd0 || a_in.ready !== 1'b0) begin
      failures++; $display("FAIL mid_state valid=%b data=%h occ=%0d stall=%0d ready=%b exp=0/00/0/0/0", a_out.valid, a_out.data, a_occ, a_stall, a_in.ready);
    end
    rst = 0;
    #1;
    checks++;
    if (a_in.ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", a_in.ready); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    c_in.valid = 1; c_in.data = 8'h05; c_out.ready = 1;
    step();
    c_in.valid = 0; c_out.ready = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15 || k == 16 || k == 17) begin
        checks++;
        if (c_stall !== 4'(k)) begin failures++; $display("FAIL wrap_%0d got=%0d exp=%0d", k, c_stall, 4'(k)); end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_streaming();
    test_skid_backpressure();
    test_single_backpressure();
    test_flush();
    test_reset_midstream();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
